// File: rtl/uart_apb_regif.sv
// APB3 register front-end for the UART TX/RX FIFO pair with registered wait states,
// bounded FIFO wait, PSLVERR and a soft-reset pulse. Optional interrupt: UART_APB_IRQ_EN.
module uart_apb_regif #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 32,
  parameter int WAIT_TIMEOUT = 16,
  parameter int RST_CYCLES   = 4
) (
  input  logic                  pclk,
  input  logic                  PRESET,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]           PWDATA,
  input  logic                  PSELx,
  input  logic                  PWRITE,
  input  logic                  PENABLE,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] rx_fifo_dataOut,
  input  logic                  rx_fifo_Empty,
  input  logic                  rx_fifo_Full,
  input  logic                  tx_fifo_Full,
  input  logic                  tx_fifo_Empty,
  output logic                  tx_fifo_writeEn,
  output logic                  rx_fifo_readEn,
  output logic [DATA_WIDTH-1:0] tx_fifo_dataIn,
  output logic                  uart_reset
`ifdef UART_APB_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam int RST_W = $clog2(RST_CYCLES + 1);

  logic [1:0]            state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  err_reg;
  logic [RST_W-1:0]      rst_cnt_reg;
  logic                  uart_reset_reg;
  logic                  soft_rst_start_reg;
  logic                  pready_reg, pslverr_reg, tx_we_reg, rx_re_reg;
  logic [31:0]           prdata_reg;
  logic [DATA_WIDTH-1:0] tx_data_reg;

  logic [1:0]  offset;
  logic        is_data, is_status, is_ctrl;
  logic        xfer_ok, xfer_bad;
  logic        finish, finish_err, finish_ok, timeout;
  logic [31:0] rd_word, ctrl_word;
  logic        unused_bits;

  assign unused_bits = ^{PADDR[ADDR_WIDTH-1:4], PADDR[1:0], PWDATA[31:DATA_WIDTH]};

  assign offset    = PADDR[3:2];
  assign is_data   = (offset == OFF_DATA);
  assign is_status = (offset == OFF_STATUS);
  assign is_ctrl   = (offset == OFF_CTRL);
  assign xfer_ok   = is_data ? (PWRITE ? ~tx_fifo_Full : ~rx_fifo_Empty) : 1'b1;
  // The FIFOs are held off while the UART core is in soft reset.
  assign xfer_bad  = (offset == 2'd3) | (is_data & uart_reset_reg);
  assign finish_ok = finish & ~finish_err;

  always_comb begin
    rd_word = '0;
    case (offset)
      OFF_DATA:   rd_word = {{(32-DATA_WIDTH){1'b0}}, rx_fifo_dataOut};
      OFF_STATUS: rd_word = {27'd0, err_reg, tx_fifo_Full, tx_fifo_Empty, rx_fifo_Full, rx_fifo_Empty};
      OFF_CTRL:   rd_word = ctrl_word;
      default:    rd_word = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    finish     = 1'b0;
    finish_err = 1'b0;
    timeout    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (PSELx && PENABLE) begin
          if (xfer_bad) begin
            finish     = 1'b1;
            finish_err = 1'b1;
          end else if (xfer_ok) begin
            finish = 1'b1;
          end else begin
            state_next = S_WAIT;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (!PSELx) begin
          state_next = S_IDLE;
        end else if (xfer_ok) begin
          finish = 1'b1;
        end else if (cnt_reg == CNT_W'(WAIT_TIMEOUT)) begin
          finish     = 1'b1;
          finish_err = 1'b1;
          timeout    = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (finish) state_next = S_DONE;
  end

  always_ff @(posedge pclk) begin
    if (PRESET) begin
      state_reg          <= S_IDLE;
      cnt_reg            <= '0;
      err_reg            <= 1'b0;
      pready_reg         <= 1'b0;
      pslverr_reg        <= 1'b0;
      tx_we_reg          <= 1'b0;
      rx_re_reg          <= 1'b0;
      prdata_reg         <= '0;
      tx_data_reg        <= '0;
      soft_rst_start_reg <= 1'b0;
    end else begin
      state_reg          <= state_next;
      cnt_reg            <= cnt_next;
      pready_reg         <= finish;
      pslverr_reg        <= finish_err;
      tx_we_reg          <= finish_ok & is_data & PWRITE;
      rx_re_reg          <= finish_ok & is_data & ~PWRITE;
      prdata_reg         <= (finish_ok & ~PWRITE) ? rd_word : '0;
      soft_rst_start_reg <= finish_ok & PWRITE & is_ctrl & PWDATA[0];
      if (finish_ok && is_data && PWRITE) tx_data_reg <= PWDATA[DATA_WIDTH-1:0];
      if (timeout) err_reg <= 1'b1;
      else if (finish_ok && PWRITE && is_status && PWDATA[4]) err_reg <= 1'b0;
    end
  end

  // Pulse starts the cycle after the CTRL write completes; a new write reloads it.
  always_ff @(posedge pclk) begin
    if (PRESET) begin
      uart_reset_reg <= 1'b0;
      rst_cnt_reg    <= '0;
    end else if (soft_rst_start_reg) begin
      uart_reset_reg <= 1'b1;
      rst_cnt_reg    <= RST_W'(RST_CYCLES - 1);
    end else if (rst_cnt_reg != '0) begin
      rst_cnt_reg <= rst_cnt_reg - RST_W'(1);
    end else begin
      uart_reset_reg <= 1'b0;
    end
  end

`ifdef UART_APB_IRQ_EN
  logic [2:0] irq_en_reg;
  logic       irq_reg;

  always_ff @(posedge pclk) begin
    if (PRESET) begin
      irq_en_reg <= '0;
      irq_reg    <= 1'b0;
    end else begin
      if (finish_ok && PWRITE && is_ctrl) irq_en_reg <= PWDATA[3:1];
      irq_reg <= |(irq_en_reg & {err_reg, tx_fifo_Empty, ~rx_fifo_Empty});
    end
  end

  assign ctrl_word = {28'd0, irq_en_reg, 1'b0};
  assign irq       = irq_reg;
`else
  assign ctrl_word = '0;
`endif

  assign PREADY          = pready_reg;
  assign PSLVERR         = pslverr_reg;
  assign PRDATA          = prdata_reg;
  assign tx_fifo_writeEn = tx_we_reg;
  assign rx_fifo_readEn  = rx_re_reg;
  assign tx_fifo_dataIn  = tx_data_reg;
  assign uart_reset      = uart_reset_reg;

endmodule

// File: tb/tb_uart_apb_regif.sv
// Self-checking bench for uart_apb_regif: scoreboarded APB transfers, FIFO wait/timeout,
// soft reset, unmapped access, abort and mid-transfer reset.
module tb_uart_apb_regif;

  localparam int DW = 8;
  localparam int WT = 16;
  localparam int RC = 4;
`ifdef UART_APB_IRQ_EN
  localparam logic [31:0] CTRL_RB_MASK = 32'h0000_000E;
`else
  localparam logic [31:0] CTRL_RB_MASK = 32'h0000_0000;
`endif

  logic          pclk;
  logic          PRESET;
  logic [31:0]   PADDR;
  logic [31:0]   PWDATA;
  logic          PSELx, PWRITE, PENABLE;
  logic [31:0]   PRDATA;
  logic          PREADY, PSLVERR;
  logic [DW-1:0] rx_fifo_dataOut;
  logic          rx_fifo_Empty, rx_fifo_Full, tx_fifo_Full, tx_fifo_Empty;
  logic          tx_fifo_writeEn, rx_fifo_readEn;
  logic [DW-1:0] tx_fifo_dataIn;
  logic          uart_reset;
`ifdef UART_APB_IRQ_EN
  logic          irq;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
    logic        we;
    logic        re;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rst_hi_cnt = 0;
  logic m_err = 1'b0;

  uart_apb_regif #(.DATA_WIDTH(DW), .ADDR_WIDTH(32), .WAIT_TIMEOUT(WT), .RST_CYCLES(RC)) dut (
    .pclk            (pclk),
    .PRESET          (PRESET),
    .PADDR           (PADDR),
    .PWDATA          (PWDATA),
    .PSELx           (PSELx),
    .PWRITE          (PWRITE),
    .PENABLE         (PENABLE),
    .PRDATA          (PRDATA),
    .PREADY          (PREADY),
    .PSLVERR         (PSLVERR),
    .rx_fifo_dataOut (rx_fifo_dataOut),
    .rx_fifo_Empty   (rx_fifo_Empty),
    .rx_fifo_Full    (rx_fifo_Full),
    .tx_fifo_Full    (tx_fifo_Full),
    .tx_fifo_Empty   (tx_fifo_Empty),
    .tx_fifo_writeEn (tx_fifo_writeEn),
    .rx_fifo_readEn  (rx_fifo_readEn),
    .tx_fifo_dataIn  (tx_fifo_dataIn),
    .uart_reset      (uart_reset)
`ifdef UART_APB_IRQ_EN
    ,
    .irq             (irq)
`endif
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(negedge pclk) if (uart_reset === 1'b1) rst_hi_cnt <= rst_hi_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  function automatic logic [31:0] status_exp();
    return {27'd0, m_err, tx_fifo_Full, tx_fifo_Empty, rx_fifo_Full, rx_fifo_Empty};
  endfunction

  task automatic apb_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_waits,
                          input bit rx_release);
    exp_t e;
    exp_t got;
    int   waits;
    bit   stray, done;
    logic [1:0] off;
    off     = addr[3:2];
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.waits = exp_waits;
    e.we    = wr && (off == 2'd0) && !exp_err;
    e.re    = !wr && (off == 2'd0) && !exp_err;
    sb_q.push_back(e);
    @(negedge pclk);
    checks++;
    if (PREADY !== 1'b0 || tx_fifo_writeEn !== 1'b0 || rx_fifo_readEn !== 1'b0) begin
      errors++;
      $display("FAIL idle_before_xfer: PREADY=%b writeEn=%b readEn=%b, required 0 0 0",
               PREADY, tx_fifo_writeEn, rx_fifo_readEn);
    end
    PSELx = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata;
    @(negedge pclk);
    PENABLE = 1'b1;
    if (rx_release) fork
      begin
        repeat (3) @(negedge pclk);
        rx_fifo_Empty = 1'b0;
      end
    join_none
    waits = 1; stray = 0; done = 0;
    while (!done) begin
      @(negedge pclk);
      if (PREADY === 1'b1) done = 1;
      else begin
        if (tx_fifo_writeEn !== 1'b0 || rx_fifo_readEn !== 1'b0) stray = 1;
        waits++;
        if (waits > 100) begin
          checks++; errors++;
          $display("FAIL xfer_timeout: addr=%h no PREADY after %0d cycles, required within %0d",
                   addr, waits, exp_waits);
          done = 1;
        end
      end
    end
    got = sb_q.pop_front();
    checks++;
    if (waits !== got.waits) begin
      errors++; $display("FAIL wait_states addr=%h: got %0d, required %0d", addr, waits, got.waits);
    end
    checks++;
    if (PSLVERR !== got.err) begin
      errors++; $display("FAIL pslverr addr=%h: got %b, required %b", addr, PSLVERR, got.err);
    end
    checks++;
    if (PRDATA !== got.rdata) begin
      errors++; $display("FAIL prdata addr=%h: got %h, required %h", addr, PRDATA, got.rdata);
    end
    checks++;
    if (tx_fifo_writeEn !== got.we || rx_fifo_readEn !== got.re || stray) begin
      errors++;
      $display("FAIL strobes addr=%h: writeEn=%b readEn=%b early=%b, required %b %b 0",
               addr, tx_fifo_writeEn, rx_fifo_readEn, stray, got.we, got.re);
    end
    $display("xfer %s addr=%h wdata=%h waits=%0d prdata=%h pslverr=%b",
             wr ? "WR" : "RD", addr, wdata, waits, PRDATA, PSLVERR);
    PSELx = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (3) @(negedge pclk);
    checks++;
    if ({PREADY, PSLVERR, tx_fifo_writeEn, rx_fifo_readEn, uart_reset} !== 5'b0 ||
        PRDATA !== 32'd0 || tx_fifo_dataIn !== '0) begin
      errors++;
      $display("FAIL reset_outputs: PREADY=%b PSLVERR=%b we=%b re=%b ur=%b PRDATA=%h txd=%h, required all 0",
               PREADY, PSLVERR, tx_fifo_writeEn, rx_fifo_readEn, uart_reset, PRDATA, tx_fifo_dataIn);
    end
    PRESET = 1'b0;
    apb_xfer(32'h4, 32'h0, 1'b0, status_exp(), 1'b0, 1, 1'b0);
  endtask

  task automatic test_write_data();
    apb_xfer(32'h0, 32'h5A, 1'b1, 32'h0, 1'b0, 1, 1'b0);
    checks++;
    if (tx_fifo_dataIn !== 8'h5A) begin
      errors++; $display("FAIL tx_data_t1: got %h, required 5a", tx_fifo_dataIn);
    end
  endtask

  task automatic test_read_wait();
    rx_fifo_dataOut = 8'hC3;
    rx_fifo_Empty   = 1'b1;
    apb_xfer(32'h0, 32'h0, 1'b0, 32'h0000_00C3, 1'b0, 4, 1'b1);
    rx_fifo_Empty = 1'b1;
  endtask

  task automatic test_timeout();
    tx_fifo_Full  = 1'b1;
    tx_fifo_Empty = 1'b0;
    apb_xfer(32'h0, 32'h11, 1'b1, 32'h0, 1'b1, WT + 1, 1'b0);
    m_err = 1'b1;
    apb_xfer(32'h4, 32'h0, 1'b0, status_exp(), 1'b0, 1, 1'b0);
    checks++;
    if (tx_fifo_dataIn !== 8'h5A) begin
      errors++; $display("FAIL tx_data_after_timeout: got %h, required 5a", tx_fifo_dataIn);
    end
    tx_fifo_Full  = 1'b0;
    tx_fifo_Empty = 1'b1;
  endtask

  task automatic test_soft_reset();
    int c0;
    apb_xfer(32'h8, 32'h1, 1'b1, 32'h0, 1'b0, 1, 1'b0);
    checks++;
    if (uart_reset !== 1'b0) begin
      errors++; $display("FAIL uart_reset_in_done: got %b, required 0", uart_reset);
    end
    c0 = rst_hi_cnt;
    apb_xfer(32'h0, 32'h77, 1'b1, 32'h0, 1'b1, 1, 1'b0);
    repeat (8) @(negedge pclk);
    checks++;
    if (rst_hi_cnt - c0 !== RC || uart_reset !== 1'b0) begin
      errors++;
      $display("FAIL uart_reset_len: high %0d cycles now=%b, required %0d cycles now=0",
               rst_hi_cnt - c0, uart_reset, RC);
    end
  endtask

  task automatic test_unmapped();
    apb_xfer(32'hC, 32'h0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    apb_xfer(32'hC, 32'hFF, 1'b1, 32'h0, 1'b1, 1, 1'b0);
    apb_xfer(32'h4, 32'h10, 1'b1, 32'h0, 1'b0, 1, 1'b0);
    m_err = 1'b0;
    apb_xfer(32'h4, 32'h0, 1'b0, status_exp(), 1'b0, 1, 1'b0);
  endtask

  task automatic test_ctrl_readback();
    apb_xfer(32'h8, 32'hE, 1'b1, 32'h0, 1'b0, 1, 1'b0);
    apb_xfer(32'h8, 32'h0, 1'b0, CTRL_RB_MASK, 1'b0, 1, 1'b0);
    checks++;
    if (uart_reset !== 1'b0) begin
      errors++; $display("FAIL ctrl_no_soft_reset: uart_reset=%b, required 0", uart_reset);
    end
  endtask

  task automatic test_back_to_back();
    apb_xfer(32'h0, 32'h133, 1'b1, 32'h0, 1'b0, 1, 1'b0);
    checks++;
    if (tx_fifo_dataIn !== 8'h33) begin
      errors++; $display("FAIL tx_data_b2b0: got %h, required 33", tx_fifo_dataIn);
    end
    apb_xfer(32'h0, 32'hA7, 1'b1, 32'h0, 1'b0, 1, 1'b0);
    checks++;
    if (tx_fifo_dataIn !== 8'hA7) begin
      errors++; $display("FAIL tx_data_b2b1: got %h, required a7", tx_fifo_dataIn);
    end
    rx_fifo_Empty = 1'b0;
    rx_fifo_dataOut = 8'h81;
    apb_xfer(32'h0, 32'h0, 1'b0, 32'h81, 1'b0, 1, 1'b0);
    rx_fifo_dataOut = 8'h5E;
    apb_xfer(32'h0, 32'h0, 1'b0, 32'h5E, 1'b0, 1, 1'b0);
    rx_fifo_Empty = 1'b1;
  endtask

  task automatic test_abort();
    bit seen;
    tx_fifo_Full = 1'b1;
    @(negedge pclk);
    PSELx = 1'b1; PENABLE = 1'b0; PADDR = 32'h0; PWRITE = 1'b1; PWDATA = 32'h44;
    @(negedge pclk);
    PENABLE = 1'b1;
    seen = 0;
    repeat (3) begin
      @(negedge pclk);
      if (PREADY !== 1'b0 || tx_fifo_writeEn !== 1'b0) seen = 1;
    end
    PSELx = 1'b0; PENABLE = 1'b0; tx_fifo_Full = 1'b0;
    repeat (2) begin
      @(negedge pclk);
      if (PREADY !== 1'b0 || tx_fifo_writeEn !== 1'b0) seen = 1;
    end
    checks++;
    if (seen || tx_fifo_dataIn !== 8'hA7) begin
      errors++;
      $display("FAIL abort_side_effect: activity=%b txd=%h, required 0 a7", seen, tx_fifo_dataIn);
    end
    apb_xfer(32'h4, 32'h0, 1'b0, status_exp(), 1'b0, 1, 1'b0);
  endtask

  task automatic test_preset_mid();
    apb_xfer(32'h8, 32'h1, 1'b1, 32'h0, 1'b0, 1, 1'b0);
    @(negedge pclk);
    checks++;
    if (uart_reset !== 1'b1) begin
      errors++; $display("FAIL soft_reset_start: uart_reset=%b, required 1", uart_reset);
    end
    PRESET = 1'b1;
    @(negedge pclk);
    checks++;
    if (uart_reset !== 1'b0) begin
      errors++; $display("FAIL preset_drops_reset: uart_reset=%b, required 0", uart_reset);
    end
    PRESET = 1'b0;
    m_err = 1'b0;
    tx_fifo_Full = 1'b1;
    @(negedge pclk);
    PSELx = 1'b1; PENABLE = 1'b0; PADDR = 32'h0; PWRITE = 1'b1; PWDATA = 32'h99;
    @(negedge pclk);
    PENABLE = 1'b1;
    repeat (3) @(negedge pclk);
    PRESET = 1'b1;
    @(negedge pclk);
    checks++;
    if (PREADY !== 1'b0 || tx_fifo_writeEn !== 1'b0 || tx_fifo_dataIn !== 8'h00) begin
      errors++;
      $display("FAIL preset_mid_xfer: PREADY=%b we=%b txd=%h, required 0 0 00",
               PREADY, tx_fifo_writeEn, tx_fifo_dataIn);
    end
    PSELx = 1'b0; PENABLE = 1'b0; PRESET = 1'b0; tx_fifo_Full = 1'b0;
    apb_xfer(32'h4, 32'h0, 1'b0, status_exp(), 1'b0, 1, 1'b0);
  endtask

`ifdef UART_APB_IRQ_EN
  task automatic test_irq();
    apb_xfer(32'h8, 32'h2, 1'b1, 32'h0, 1'b0, 1, 1'b0);
    rx_fifo_Empty = 1'b1;
    repeat (2) @(negedge pclk);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_idle: got %b, required 0", irq);
    end
    rx_fifo_Empty = 1'b0;
    @(negedge pclk);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_rx_not_empty: got %b, required 1", irq);
    end
    rx_fifo_Empty = 1'b1;
    @(negedge pclk);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_clear: got %b, required 0", irq);
    end
  endtask
`endif

  initial begin
    PRESET = 1'b1; PADDR = '0; PWDATA = '0; PSELx = 1'b0; PWRITE = 1'b0; PENABLE = 1'b0;
    rx_fifo_dataOut = '0; rx_fifo_Empty = 1'b1; rx_fifo_Full = 1'b0;
    tx_fifo_Full = 1'b0; tx_fifo_Empty = 1'b1;
    test_reset();
    test_write_data();
    test_read_wait();
    test_timeout();
    test_soft_reset();
    test_unmapped();
    test_ctrl_readback();
    test_back_to_back();
    test_abort();
    test_preset_mid();
`ifdef UART_APB_IRQ_EN
    test_irq();
`endif
    checks++;
    if (sb_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d left, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
